// File: rtl/regfile_sb_pkg.sv
// Shared widths and types for the register file / scoreboard slice.
// Imported by the interface, the counter and the top.
package regfile_sb_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int XLEN       = 16;
  localparam int NREGS      = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Bundle between decode/write-back (master) and regfile_sb (slave).
// Carries write-back, two read ports, issue request and status.
interface regfile_sb_if;
  import regfile_sb_pkg::*;

  logic      wb_valid_i;
  reg_addr_t wb_rd_i;
  xlen_t     wb_data_i;
  reg_addr_t rs1_addr_i;
  reg_addr_t rs2_addr_i;
  xlen_t     rs1_data_o;
  xlen_t     rs2_data_o;
  logic      rs1_busy_o;
  logic      rs2_busy_o;
  logic      issue_valid_i;
  reg_addr_t issue_rd_i;
  logic      issue_ready_o;
  logic      sb_err_o;

  modport master (
    output wb_valid_i, wb_rd_i, wb_data_i,
    output rs1_addr_i, rs2_addr_i,
    output issue_valid_i, issue_rd_i,
    input  rs1_data_o, rs2_data_o,
    input  rs1_busy_o, rs2_busy_o,
    input  issue_ready_o, sb_err_o
  );

  modport slave (
    input  wb_valid_i, wb_rd_i, wb_data_i,
    input  rs1_addr_i, rs2_addr_i,
    input  issue_valid_i, issue_rd_i,
    output rs1_data_o, rs2_data_o,
    output rs1_busy_o, rs2_busy_o,
    output issue_ready_o, sb_err_o
  );
endinterface

// File: rtl/regfile_sb_counter.sv
// sb_counter: saturating up/down pending-writer counter.
// Ports: clk_i, rst_ni, i_inc, i_dec -> o_cnt, o_zero, o_full.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero,
  output logic         o_full
);
  logic [W-1:0] r_cnt;
  logic         w_inc;
  logic         w_dec;

  assign o_zero = (r_cnt == '0);
  assign o_full = &r_cnt;

  // Ends are masked here so the count can never wrap.
  assign w_inc = i_inc && !o_full;
  assign w_dec = i_dec && !o_zero;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + W'(1);
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// 8x16 register file with write-through bypass and pending-write scoreboard.
// Ports: clk_i, rst_ni (sync, active low), bus (regfile_sb_if.slave).
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  regfile_sb_if.slave   bus
);
  xlen_t             r_regs [NREGS];
  logic              r_sb_err;
  logic [PEND_W-1:0] w_pend [NREGS];
  logic [NREGS-1:0]  w_zero;
  logic [NREGS-1:0]  w_full;
  logic [NREGS-1:0]  w_inc;
  logic [NREGS-1:0]  w_dec;
  logic              w_ready;
  logic              w_wb_live;
  logic              w_orphan;

  assign w_pend[0] = '0;
  assign w_zero[0] = 1'b1;
  assign w_full[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_counter #(.W(PEND_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_inc  (w_inc[r]),
      .i_dec  (w_dec[r]),
      .o_cnt  (w_pend[r]),
      .o_zero (w_zero[r]),
      .o_full (w_full[r])
    );
  end

  assign w_wb_live = bus.wb_valid_i && (bus.wb_rd_i != '0);
  // x0 never fills, so ready here is purely registered state.
  assign w_ready   = !w_full[bus.issue_rd_i];
  assign w_orphan  = w_wb_live && w_zero[bus.wb_rd_i];

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_inc[r] = bus.issue_valid_i && w_ready &&
                 (bus.issue_rd_i == reg_addr_t'(r));
      w_dec[r] = bus.wb_valid_i &&
                 (bus.wb_rd_i == reg_addr_t'(r));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      if (w_wb_live) begin
        r_regs[bus.wb_rd_i] <= bus.wb_data_i;
      end
      if (w_orphan) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  function automatic xlen_t rd_val(reg_addr_t a);
    if (a == '0) return '0;
    if (bus.wb_valid_i && bus.wb_rd_i == a) return bus.wb_data_i;
    return r_regs[a];
  endfunction

  // A last writer committing now is covered by the bypass.
  function automatic logic busy(reg_addr_t a);
    logic last;
    last = (w_pend[a] == PEND_W'(1)) && bus.wb_valid_i &&
           (bus.wb_rd_i == a);
    return (a != '0) && !w_zero[a] && !last;
  endfunction

  always_comb begin
    bus.rs1_data_o = rd_val(bus.rs1_addr_i);
    bus.rs2_data_o = rd_val(bus.rs2_addr_i);
    bus.rs1_busy_o = busy(bus.rs1_addr_i);
    bus.rs2_busy_o = busy(bus.rs2_addr_i);
  end

  assign bus.issue_ready_o = w_ready;
  assign bus.sb_err_o      = r_sb_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
// Inputs change 1ns after posedge; outputs checked 2ns after.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  regfile_sb_if bus();

  regfile_sb dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid_i    = 1'b0;
    bus.wb_rd_i       = '0;
    bus.wb_data_i     = '0;
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rs1_addr_i = '0;
    bus.rs2_addr_i = '0;
    idle();
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd3;
    bus.wb_data_i  = 16'hDEAD;
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    bus.rs1_addr_i = 3'd3;
    bus.rs2_addr_i = 3'd0;
    bus.issue_rd_i = 3'd5;
    #1;
    chk("rst_rs1_data", bus.rs1_data_o, 16'h0);
    chk("rst_rs2_data", bus.rs2_data_o, 16'h0);
    chk("rst_rs1_busy", 16'(bus.rs1_busy_o), 16'h0);
    chk("rst_rs2_busy", 16'(bus.rs2_busy_o), 16'h0);
    chk("rst_ready", 16'(bus.issue_ready_o), 16'h1);
    chk("rst_err", 16'(bus.sb_err_o), 16'h0);

    // issue rd=5; busy must not rise in the issue cycle
    bus.issue_valid_i = 1'b1;
    bus.rs1_addr_i = 3'd5;
    #1;
    chk("issue_same_cyc_busy", 16'(bus.rs1_busy_o), 16'h0);
    tick();
    idle();
    #1;
    chk("r5_busy", 16'(bus.rs1_busy_o), 16'h1);
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd5;
    bus.wb_data_i  = 16'hBEEF;
    #1;
    chk("r5_bypass_busy", 16'(bus.rs1_busy_o), 16'h0);
    chk("r5_bypass_data", bus.rs1_data_o, 16'hBEEF);
    tick();
    idle();
    #1;
    chk("r5_after_busy", 16'(bus.rs1_busy_o), 16'h0);
    chk("r5_after_data", bus.rs1_data_o, 16'hBEEF);
    chk("r5_no_err", 16'(bus.sb_err_o), 16'h0);

    // fill rd=2 to saturation
    bus.issue_rd_i = 3'd2;
    bus.issue_valid_i = 1'b1;
    tick();
    chk("r2_ready_p1", 16'(bus.issue_ready_o), 16'h1);
    tick();
    tick();
    #1;
    chk("r2_ready_full", 16'(bus.issue_ready_o), 16'h0);
    tick();
    #1;
    chk("r2_4th_ignored", 16'(bus.issue_ready_o), 16'h0);
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i = 3'd3;
    #1;
    chk("r3_ready", 16'(bus.issue_ready_o), 16'h1);
    bus.issue_rd_i = 3'd2;
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd2;
    bus.wb_data_i  = 16'h2222;
    bus.rs2_addr_i = 3'd2;
    #1;
    chk("r2_ready_ignores_wb", 16'(bus.issue_ready_o), 16'h0);
    chk("r2_busy_pend3_wb", 16'(bus.rs2_busy_o), 16'h1);
    tick();
    idle();
    bus.issue_rd_i = 3'd2;
    #1;
    chk("r2_ready_back", 16'(bus.issue_ready_o), 16'h1);
    chk("r2_busy_pend2", 16'(bus.rs2_busy_o), 16'h1);
    chk("r2_data", bus.rs2_data_o, 16'h2222);

    // write-back to x0
    bus.rs1_addr_i = 3'd0;
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd0;
    bus.wb_data_i  = 16'h1234;
    #1;
    chk("x0_bypass", bus.rs1_data_o, 16'h0);
    tick();
    idle();
    #1;
    chk("x0_after", bus.rs1_data_o, 16'h0);
    chk("x0_no_err", 16'(bus.sb_err_o), 16'h0);
    chk("x0_r2_busy", 16'(bus.rs2_busy_o), 16'h1);

    // orphan write-back to rd=4
    bus.rs1_addr_i = 3'd4;
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd4;
    bus.wb_data_i  = 16'h00AA;
    tick();
    idle();
    #1;
    chk("r4_data", bus.rs1_data_o, 16'h00AA);
    chk("r4_err", 16'(bus.sb_err_o), 16'h1);
    chk("r4_busy", 16'(bus.rs1_busy_o), 16'h0);
    tick();
    tick();
    chk("err_sticky", 16'(bus.sb_err_o), 16'h1);

    // pend[6]=1, then simultaneous issue and write-back
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 3'd6;
    bus.rs1_addr_i    = 3'd6;
    tick();
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd6;
    bus.wb_data_i  = 16'h0066;
    #1;
    chk("r6_busy_last_wb", 16'(bus.rs1_busy_o), 16'h0);
    tick();
    idle();
    #1;
    chk("r6_busy_hold", 16'(bus.rs1_busy_o), 16'h1);
    chk("r6_data", bus.rs1_data_o, 16'h0066);

    // mid-run reset with a write-back in the reset cycle
    rst_n = 1'b0;
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 3'd6;
    bus.wb_data_i  = 16'hFFFF;
    tick();
    idle();
    rst_n = 1'b1;
    bus.issue_rd_i = 3'd2;
    #1;
    chk("rst2_r6_busy", 16'(bus.rs1_busy_o), 16'h0);
    chk("rst2_r6_data", bus.rs1_data_o, 16'h0);
    chk("rst2_r2_busy", 16'(bus.rs2_busy_o), 16'h0);
    chk("rst2_r2_data", bus.rs2_data_o, 16'h0);
    chk("rst2_ready", 16'(bus.issue_ready_o), 16'h1);
    chk("rst2_err", 16'(bus.sb_err_o), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
